multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle successor to the single-cycle miniRV decoder: a Moore FSM that sequences each
//  instruction through FETCH/DECODE/EXEC/MEM/WB with req/ack handshakes to IROM and DRAM.
//  It emits the same control fields as the single-cycle decoder, using the defines.vh encodings.
//  It adds an optional extended branch set, illegal-instruction and bus-timeout traps, and a retired-instruction counter.
//  Sits between the IR/PC datapath and the memory ports of mySoC.
// PARAMETERS
//  EXT_BRANCH  1   1: decode BGE/BLTU/BGEU (`ALU_BGE/`ALU_BLTU/`ALU_BGEU); 0: those func3 are illegal
//  TIMEOUT     16  max wait cycles on imem/dmem ack before TRAP; 0 disables the timeout
//  CNT_W       32  width of instret counter
// PORTS
//  cpu_clk       in   1      clock, all state updates on the rising edge
//  cpu_rst       in   1      synchronous, active-high reset
//  inst          in   32     IR contents; valid from DECODE onward
//  imem_req      out  1      fetch request, high throughout FETCH
//  imem_ack      in   1      fetch done; inst is latched into IR on ack
//  dmem_req      out  1      data request, high throughout MEM
//  dmem_ack      in   1      data access done
//  ir_we         out  1      IR write strobe
//  pc_we         out  1      PC write strobe, once per instruction
//  npc_op        out  4      `NPC_* select
//  sext_op       out  3      `EXT_* select
//  rf_wsel       out  3      `WB_* select
//  rf_we         out  1      register-file write strobe, WB state only
//  alu_b_sel     out  1      `ALUB_RS2 / `ALUB_EXT
//  alu_op        out  4      `ALU_* select
//  en_data_trans out  1      `WRITE in MEM for SW, else `READ
//  illegal       out  1      sticky: illegal instruction trapped
//  timeout       out  1      sticky: ack timeout trapped
//  instret       out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W
//  state_o       out  3      current state (debug): FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7
// BEHAVIOUR
//  Reset: state=FETCH, wait counter=0, instret=0, illegal=timeout=0. Control fields reset to
//   npc_op=`NPC_PC4, sext_op=`EXT_I, rf_wsel=`WB_PC4, alu_b_sel=`ALUB_EXT, alu_op=`ALU_ADD,
//   en_data_trans=`READ. Strobes (ir_we, pc_we, rf_we, dmem_req) are 0. imem_req=1 (FETCH).
//  Reset mid-instruction aborts it: no pc_we or rf_we is issued and instret is unchanged.
//  FETCH: imem_req=1. On imem_ack: ir_we=1 in the same cycle, then go to DECODE.
//  DECODE: decode inst into the registered control fields, which hold until the next DECODE.
//   Opcode map is the single-cycle decoder's, with these additions:
//    - SRA/SRAI: selected by inst[30]=1.
//    - SUB: R-type func3=000 with inst[30]=1 -> `ALU_SUB.
//    - I-type shifts: sext_op=`EXT_SHIFT for func3 3'b001 and 3'b101.
//   Illegal (-> TRAP, illegal=1) when any of:
//    - opcode is not one of the 8 miniRV opcodes;
//    - R-type/I-type func3 is 010 or 011;
//    - R-type func7 is not 0000000/0100000, or inst[30]=1 with func3 not 000/101;
//    - B-type func3 is 010 or 011, or 101/110/111 when EXT_BRANCH=0.
//  EXEC: ALU operates. B-type: pc_we=1, then FETCH (3 cycles total). LW/SW: go to MEM.
//   All other opcodes: go to WB.
//  MEM: dmem_req=1, en_data_trans=`WRITE only for SW. On dmem_ack: SW asserts pc_we=1 that cycle
//   and goes to FETCH; LW goes to WB.
//  WB: rf_we=1 and pc_we=1 for one cycle, then FETCH.
//  Zero-wait latency (ack high in the request cycle): ALU/LUI/JAL/JALR=4, LW=5, SW=4, B=3 cycles.
//  Wait counter: cleared on entry to FETCH/MEM; increments each cycle req is high without ack.
//   When TIMEOUT!=0 and the counter reaches TIMEOUT with ack still low -> TRAP, timeout=1.
//   An ack arriving in the same cycle the counter reaches TIMEOUT wins: no trap.
//  instret increments in the cycle pc_we=1 and wraps from all-ones to 0.
//  TRAP: all strobes and reqs are 0. Remains in TRAP until cpu_rst; illegal/timeout stay held.
// TESTING
//  addi x1,x0,5 with imem_ack tied high -> ir_we@c0, rf_we+pc_we@c3, alu_op=`ALU_ADD,
//   sext_op=`EXT_I, instret=1.
//  lw with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, rf_wsel=`WB_OUTSIDE,
//   rf_we one cycle after ack.
//  EXT_BRANCH=0, inst=bge (func3=101) -> illegal=1, state_o=7, no pc_we; cpu_rst -> FETCH, flags clear.
//  TIMEOUT=4 with imem_ack held low -> TRAP after 4 wait cycles, timeout=1; ack on cycle 4 -> no trap.
//  sub and srai (inst[30]=1) -> `ALU_SUB, and `ALU_SRA with `EXT_SHIFT;
//   R-type func7=0000001 -> illegal.
//  CNT_W=4, retire 17 instructions -> instret=1 (wrap); cpu_rst asserted in MEM of sw -> no pc_we.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle miniRV control FSM: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB with req/ack handshakes to IROM and DRAM, and emits
// the datapath control fields. Includes traps for illegal instructions and bus
// timeouts, plus a retired-instruction counter.
//
// Ports:
//   cpu_clk, cpu_rst       clock, synchronous active-high reset
//   inst                   IR contents, valid from DECODE onward
//   imem_req / imem_ack    instruction fetch handshake
//   dmem_req / dmem_ack    data access handshake
//   ir_we, pc_we, rf_we    IR / PC / register-file write strobes
//   npc_op, sext_op, rf_wsel, alu_b_sel, alu_op, en_data_trans  control fields
//   illegal, timeout       sticky trap flags
//   instret                retired-instruction count (wraps)
//   state_o                current FSM state for debug
module multicycle_ctrl #(
  parameter bit          EXT_BRANCH = 1'b1,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic [31:0]      inst,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic [3:0]       npc_op,
  output logic [2:0]       sext_op,
  output logic [2:0]       rf_wsel,
  output logic             rf_we,
  output logic             alu_b_sel,
  output logic [3:0]       alu_op,
  output logic             en_data_trans,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);

  // Control-field encodings shared with the datapath
  localparam logic [3:0] NPC_PC4    = 4'd0;
  localparam logic [3:0] NPC_BRANCH = 4'd1;
  localparam logic [3:0] NPC_JAL    = 4'd2;
  localparam logic [3:0] NPC_JALR   = 4'd3;

  localparam logic [2:0] EXT_I     = 3'd0;
  localparam logic [2:0] EXT_S     = 3'd1;
  localparam logic [2:0] EXT_B     = 3'd2;
  localparam logic [2:0] EXT_U     = 3'd3;
  localparam logic [2:0] EXT_J     = 3'd4;
  localparam logic [2:0] EXT_SHIFT = 3'd5;

  localparam logic [2:0] WB_ALU     = 3'd0;
  localparam logic [2:0] WB_OUTSIDE = 3'd1;
  localparam logic [2:0] WB_EXT     = 3'd2;
  localparam logic [2:0] WB_PC4     = 3'd3;

  localparam logic ALUB_RS2 = 1'b0;
  localparam logic ALUB_EXT = 1'b1;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_BEQ  = 4'd8;
  localparam logic [3:0] ALU_BNE  = 4'd9;
  localparam logic [3:0] ALU_BLT  = 4'd10;
  localparam logic [3:0] ALU_BGE  = 4'd11;
  localparam logic [3:0] ALU_BLTU = 4'd12;
  localparam logic [3:0] ALU_BGEU = 4'd13;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam int unsigned          WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0]    TO_VAL = WCNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  // Instruction class remembered from DECODE to steer EXEC/MEM
  typedef enum logic [1:0] {
    CLS_OTHER  = 2'd0,
    CLS_BRANCH = 2'd1,
    CLS_LOAD   = 2'd2,
    CLS_STORE  = 2'd3
  } cls_t;

  state_t              state;
  cls_t                cls;
  logic [WCNT_W-1:0]   wait_cnt;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       b30;
  logic       f3_bad;
  logic       unused_inst;

  logic [3:0] d_npc;
  logic [2:0] d_sext;
  logic [2:0] d_wsel;
  logic       d_bsel;
  logic [3:0] d_alu;
  cls_t       d_cls;
  logic       d_illegal;

  assign opcode      = inst[6:0];
  assign f3          = inst[14:12];
  assign f7          = inst[31:25];
  assign b30         = inst[30];
  assign f3_bad      = (f3 == 3'b010) || (f3 == 3'b011);
  assign unused_inst = ^{inst[24:15], inst[11:7]};

  // Arithmetic/shift ALU op from func3; alt selects SUB/SRA
  function automatic logic [3:0] alu_fn(input logic [2:0] fn3, input logic alt);
    case (fn3)
      3'b000:  alu_fn = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  endfunction

  // Instruction decode, sampled into the control registers in DECODE
  always_comb begin
    d_npc     = NPC_PC4;
    d_sext    = EXT_I;
    d_wsel    = WB_ALU;
    d_bsel    = ALUB_EXT;
    d_alu     = ALU_ADD;
    d_cls     = CLS_OTHER;
    d_illegal = 1'b0;
    case (opcode)
      OP_R: begin
        d_bsel    = ALUB_RS2;
        d_alu     = alu_fn(f3, b30);
        d_illegal = f3_bad
                 || ((f7 != 7'b0000000) && (f7 != 7'b0100000))
                 || (b30 && (f3 != 3'b000) && (f3 != 3'b101));
      end
      OP_I: begin
        d_sext    = ((f3 == 3'b001) || (f3 == 3'b101)) ? EXT_SHIFT : EXT_I;
        // inst[30] is an immediate bit for ADDI, so only SRAI uses it
        d_alu     = alu_fn(f3, (f3 == 3'b101) && b30);
        d_illegal = f3_bad;
      end
      OP_LW: begin
        d_wsel = WB_OUTSIDE;
        d_cls  = CLS_LOAD;
      end
      OP_SW: begin
        d_sext = EXT_S;
        d_cls  = CLS_STORE;
      end
      OP_JALR: begin
        d_npc  = NPC_JALR;
        d_wsel = WB_PC4;
      end
      OP_LUI: begin
        d_sext = EXT_U;
        d_wsel = WB_EXT;
      end
      OP_JAL: begin
        d_npc  = NPC_JAL;
        d_sext = EXT_J;
        d_wsel = WB_PC4;
      end
      OP_B: begin
        d_npc  = NPC_BRANCH;
        d_sext = EXT_B;
        d_bsel = ALUB_RS2;
        d_cls  = CLS_BRANCH;
        case (f3)
          3'b000:  d_alu = ALU_BEQ;
          3'b001:  d_alu = ALU_BNE;
          3'b100:  d_alu = ALU_BLT;
          3'b101:  d_alu = ALU_BGE;
          3'b110:  d_alu = ALU_BLTU;
          3'b111:  d_alu = ALU_BGEU;
          default: d_alu = ALU_ADD;
        endcase
        d_illegal = f3_bad || (!EXT_BRANCH && (f3[2] && (f3[1:0] != 2'b00)));
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // Ack-qualified strobes fire in the ack cycle; reset suppresses them
  assign ir_we = !cpu_rst && (state == FETCH) && imem_ack;
  assign pc_we = !cpu_rst && (((state == EXEC) && (cls == CLS_BRANCH))
                           || (state == WB)
                           || ((state == MEM) && (cls == CLS_STORE) && dmem_ack));
  assign state_o = state;

  // Main FSM with registered requests, control fields and counters
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state         <= FETCH;
      cls           <= CLS_OTHER;
      wait_cnt      <= '0;
      instret       <= '0;
      illegal       <= 1'b0;
      timeout       <= 1'b0;
      imem_req      <= 1'b1;
      dmem_req      <= 1'b0;
      rf_we         <= 1'b0;
      npc_op        <= NPC_PC4;
      sext_op       <= EXT_I;
      rf_wsel       <= WB_PC4;
      alu_b_sel     <= ALUB_EXT;
      alu_op        <= ALU_ADD;
      en_data_trans <= READ;
    end else begin
      rf_we <= 1'b0;
      if (pc_we) instret <= instret + CNT_W'(1);
      case (state)
        FETCH: begin
          if (imem_ack) begin
            state    <= DECODE;
            imem_req <= 1'b0;
          end else if ((TIMEOUT != 0) && (wait_cnt == TO_VAL)) begin
            state    <= TRAP;
            timeout  <= 1'b1;
            imem_req <= 1'b0;
          end else if (wait_cnt != TO_VAL) begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        DECODE: begin
          if (d_illegal) begin
            state   <= TRAP;
            illegal <= 1'b1;
          end else begin
            state     <= EXEC;
            cls       <= d_cls;
            npc_op    <= d_npc;
            sext_op   <= d_sext;
            rf_wsel   <= d_wsel;
            alu_b_sel <= d_bsel;
            alu_op    <= d_alu;
          end
        end
        EXEC: begin
          case (cls)
            CLS_BRANCH: begin
              state    <= FETCH;
              imem_req <= 1'b1;
              wait_cnt <= '0;
            end
            CLS_LOAD, CLS_STORE: begin
              state         <= MEM;
              dmem_req      <= 1'b1;
              wait_cnt      <= '0;
              en_data_trans <= (cls == CLS_STORE) ? WRITE : READ;
            end
            default: begin
              state <= WB;
              rf_we <= 1'b1;
            end
          endcase
        end
        MEM: begin
          if (dmem_ack) begin
            dmem_req      <= 1'b0;
            en_data_trans <= READ;
            if (cls == CLS_STORE) begin
              state    <= FETCH;
              imem_req <= 1'b1;
              wait_cnt <= '0;
            end else begin
              state <= WB;
              rf_we <= 1'b1;
            end
          end else if ((TIMEOUT != 0) && (wait_cnt == TO_VAL)) begin
            state         <= TRAP;
            timeout       <= 1'b1;
            dmem_req      <= 1'b0;
            en_data_trans <= READ;
          end else if (wait_cnt != TO_VAL) begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        WB: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          wait_cnt <= '0;
        end
        TRAP: state <= TRAP;
        default: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (EXT_BRANCH=0, TIMEOUT=4, CNT_W=4).
module tb_multicycle_ctrl;

  localparam logic [3:0] NPC_PC4 = 4'd0, NPC_BRANCH = 4'd1;
  localparam logic [2:0] EXT_I = 3'd0, EXT_S = 3'd1, EXT_SHIFT = 3'd5;
  localparam logic [2:0] WB_ALU = 3'd0, WB_OUTSIDE = 3'd1, WB_PC4 = 3'd3;
  localparam logic ALUB_RS2 = 1'b0, ALUB_EXT = 1'b1;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SRA = 4'd7, ALU_BLT = 4'd10;
  localparam logic READ = 1'b0, WRITE = 1'b1;

  localparam logic [31:0] I_ADDI = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_LW   = 32'h0000_A103;  // lw x2,0(x1)
  localparam logic [31:0] I_SW   = 32'h0020_A223;  // sw x2,4(x1)
  localparam logic [31:0] I_SUB  = 32'h4020_81B3;  // sub x3,x1,x2
  localparam logic [31:0] I_SRAI = 32'h4030_D213;  // srai x4,x1,3
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;  // beq x0,x0,0
  localparam logic [31:0] I_BLT  = 32'h0020_C063;  // blt x1,x2,0
  localparam logic [31:0] I_BGE  = 32'h0020_D063;  // bge x1,x2,0
  localparam logic [31:0] I_MUL  = 32'h0220_82B3;  // func7=0000001

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic [31:0] inst;
  logic        imem_req, imem_ack, dmem_req, dmem_ack;
  logic        ir_we, pc_we, rf_we, alu_b_sel, en_data_trans, illegal, timeout;
  logic [3:0]  npc_op, alu_op;
  logic [2:0]  sext_op, rf_wsel, state_o;
  logic [3:0]  instret;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl #(.EXT_BRANCH(1'b0), .TIMEOUT(4), .CNT_W(4)) dut (
    .cpu_clk(clk), .cpu_rst(cpu_rst), .inst(inst),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .pc_we(pc_we), .npc_op(npc_op), .sext_op(sext_op),
    .rf_wsel(rf_wsel), .rf_we(rf_we), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .en_data_trans(en_data_trans), .illegal(illegal), .timeout(timeout),
    .instret(instret), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are driven here
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, then release; the current cycle becomes FETCH c0
  task automatic reset_release();
    cpu_rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    cpu_rst = 1'b0;
  endtask

  initial begin
    cpu_rst  = 1'b1;
    inst     = 32'h0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #3;
    chk("rst_state",   32'(state_o), 32'd0);
    chk("rst_imemreq", 32'(imem_req), 32'd1);
    chk("rst_dmemreq", 32'(dmem_req), 32'd0);
    chk("rst_strobes", 32'({ir_we, pc_we, rf_we}), 32'd0);
    chk("rst_npc",     32'(npc_op), 32'(NPC_PC4));
    chk("rst_sext",    32'(sext_op), 32'(EXT_I));
    chk("rst_wsel",    32'(rf_wsel), 32'(WB_PC4));
    chk("rst_bsel",    32'(alu_b_sel), 32'(ALUB_EXT));
    chk("rst_alu",     32'(alu_op), 32'(ALU_ADD));
    chk("rst_dtrans",  32'(en_data_trans), 32'(READ));
    chk("rst_flags",   32'({illegal, timeout}), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);

    // addi with imem_ack tied high: c0..c4
    adv(); cpu_rst = 1'b0; imem_ack = 1'b1; inst = I_ADDI; #2;
    chk("addi_c0_irwe",  32'(ir_we), 32'd1);
    chk("addi_c0_pcwe",  32'(pc_we), 32'd0);
    adv(); #2;
    chk("addi_c1_state", 32'(state_o), 32'd1);
    chk("addi_c1_irwe",  32'(ir_we), 32'd0);
    chk("addi_c1_ireq",  32'(imem_req), 32'd0);
    adv(); #2;
    chk("addi_c2_state", 32'(state_o), 32'd2);
    chk("addi_c2_pcwe",  32'(pc_we), 32'd0);
    adv(); #2;
    chk("addi_c3_state", 32'(state_o), 32'd4);
    chk("addi_c3_we",    32'({rf_we, pc_we}), 32'd3);
    chk("addi_alu",      32'(alu_op), 32'(ALU_ADD));
    chk("addi_sext",     32'(sext_op), 32'(EXT_I));
    chk("addi_wsel",     32'(rf_wsel), 32'(WB_ALU));
    adv(); inst = I_LW; #2;
    chk("addi_instret",  32'(instret), 32'd1);
    chk("c4_state",      32'(state_o), 32'd0);
    chk("c4_rfwe",       32'(rf_we), 32'd0);

    // lw with dmem_ack delayed 3 cycles
    adv(); adv(); adv(); #2;
    chk("lw_mem_state",  32'(state_o), 32'd3);
    chk("lw_wsel",       32'(rf_wsel), 32'(WB_OUTSIDE));
    chk("lw_dtrans",     32'(en_data_trans), 32'(READ));
    for (int i = 0; i < 4; i++) begin
      if (i != 0) begin
        adv();
        dmem_ack = (i == 3);
        #2;
      end
      chk($sformatf("lw_dreq_%0d", i), 32'(dmem_req), 32'd1);
      chk($sformatf("lw_rfwe_%0d", i), 32'(rf_we), 32'd0);
    end
    adv(); dmem_ack = 1'b0; #2;
    chk("lw_wb_state",   32'(state_o), 32'd4);
    chk("lw_wb_we",      32'({rf_we, pc_we}), 32'd3);
    chk("lw_wb_dreq",    32'(dmem_req), 32'd0);
    adv(); inst = I_SUB; #2;
    chk("lw_instret",    32'(instret), 32'd2);

    // sub then srai
    adv(); adv(); #2;
    chk("sub_alu",       32'(alu_op), 32'(ALU_SUB));
    chk("sub_bsel",      32'(alu_b_sel), 32'(ALUB_RS2));
    adv(); adv(); inst = I_SRAI; adv(); adv(); #2;
    chk("srai_alu",      32'(alu_op), 32'(ALU_SRA));
    chk("srai_sext",     32'(sext_op), 32'(EXT_SHIFT));
    chk("srai_bsel",     32'(alu_b_sel), 32'(ALUB_EXT));

    // sw with one wait cycle in MEM
    adv(); adv(); inst = I_SW; adv(); adv(); adv(); #2;
    chk("sw_mem_state",  32'(state_o), 32'd3);
    chk("sw_dtrans",     32'(en_data_trans), 32'(WRITE));
    chk("sw_sext",       32'(sext_op), 32'(EXT_S));
    chk("sw_wait_pcwe",  32'(pc_we), 32'd0);
    adv(); dmem_ack = 1'b1; #2;
    chk("sw_ack_pcwe",   32'(pc_we), 32'd1);
    chk("sw_ack_rfwe",   32'(rf_we), 32'd0);
    adv(); dmem_ack = 1'b0; inst = I_BEQ; #2;
    chk("sw_next_state", 32'(state_o), 32'd0);
    chk("sw_next_dreq",  32'({dmem_req, en_data_trans}), 32'd0);
    chk("sw_instret",    32'(instret), 32'd5);

    // beq and blt (legal even with EXT_BRANCH=0): 3-cycle branches
    adv(); adv(); #2;
    chk("beq_state",     32'(state_o), 32'd2);
    chk("beq_pcwe",      32'(pc_we), 32'd1);
    chk("beq_npc",       32'(npc_op), 32'(NPC_BRANCH));
    adv(); inst = I_BLT; #2;
    chk("beq_instret",   32'(instret), 32'd6);
    adv(); adv(); #2;
    chk("blt_alu",       32'(alu_op), 32'(ALU_BLT));
    chk("blt_pcwe",      32'(pc_we), 32'd1);

    // func7=0000001 is illegal
    adv(); inst = I_MUL; #2;
    chk("blt_instret",   32'(instret), 32'd7);
    adv(); adv(); #2;
    chk("mul_state",     32'(state_o), 32'd7);
    chk("mul_illegal",   32'(illegal), 32'd1);
    chk("mul_strobes",   32'({imem_req, dmem_req, ir_we, pc_we, rf_we}), 32'd0);
    adv(); #2;
    chk("mul_hold",      32'({state_o, illegal}), 32'({3'd7, 1'b1}));
    chk("mul_instret",   32'(instret), 32'd7);

    // bge is illegal with EXT_BRANCH=0; reset clears flags
    reset_release(); inst = I_BGE; #2;
    chk("bge_rst_state", 32'(state_o), 32'd0);
    chk("bge_rst_flags", 32'({illegal, timeout}), 32'd0);
    chk("bge_rst_ireq",  32'(imem_req), 32'd1);
    adv(); adv(); #2;
    chk("bge_state",     32'(state_o), 32'd7);
    chk("bge_illegal",   32'(illegal), 32'd1);
    chk("bge_pcwe",      32'(pc_we), 32'd0);

    // Fetch timeout: ack held low traps after cycle 4
    reset_release(); imem_ack = 1'b0; inst = I_ADDI; #2;
    repeat (4) adv();
    #2;
    chk("to_c4_state",   32'(state_o), 32'd0);
    chk("to_c4_flag",    32'(timeout), 32'd0);
    adv(); #2;
    chk("to_c5_state",   32'(state_o), 32'd7);
    chk("to_c5_flag",    32'(timeout), 32'd1);
    chk("to_c5_ireq",    32'(imem_req), 32'd0);
    adv(); #2;
    chk("to_hold",       32'({state_o, timeout}), 32'({3'd7, 1'b1}));

    // Ack in the cycle the counter reaches the limit wins
    reset_release(); imem_ack = 1'b0; #2;
    repeat (4) adv();
    imem_ack = 1'b1; #2;
    chk("ack4_irwe",     32'(ir_we), 32'd1);
    adv(); #2;
    chk("ack4_state",    32'(state_o), 32'd1);
    chk("ack4_flag",     32'(timeout), 32'd0);

    // instret wraps after 16 retirements with CNT_W=4
    reset_release(); imem_ack = 1'b1; inst = I_ADDI; #2;
    chk("wrap_start",    32'(instret), 32'd0);
    repeat (64) adv();
    #2;
    chk("wrap_16",       32'(instret), 32'd0);
    repeat (4) adv();
    inst = I_SW; #2;
    chk("wrap_17",       32'(instret), 32'd1);

    // Reset asserted in MEM of sw aborts it
    adv(); adv(); adv(); #2;
    chk("abort_mem",     32'(state_o), 32'd3);
    adv(); cpu_rst = 1'b1; dmem_ack = 1'b1; #2;
    chk("abort_pcwe",    32'(pc_we), 32'd0);
    chk("abort_instret", 32'(instret), 32'd1);
    adv(); cpu_rst = 1'b0; dmem_ack = 1'b0; imem_ack = 1'b0; #2;
    chk("abort_state",   32'(state_o), 32'd0);
    chk("abort_dreq",    32'({dmem_req, en_data_trans}), 32'd0);
    chk("abort_cnt",     32'(instret), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
